// File: rtl/pos_codec_pkg.sv
// Shared types and helpers for the bit-position codec, used by both the encoder and the rebuild side.
// The one-hot helper is sized for the widest supported vector; callers keep the low N bits.
package pos_codec_pkg;

   localparam int unsigned MAX_N = 256;

   typedef enum logic {ACCUM, HOLD} rebuild_state_t;

   // The bit is set only when pos addresses a real bit of an n-wide vector.
   function automatic logic [MAX_N-1:0] onehot_of(input int unsigned pos, input int unsigned n);
      logic [MAX_N-1:0] oh;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         oh[i] = (pos == i) && (pos < n);
      end
      return oh;
   endfunction

endpackage

// File: rtl/pos_onehot_decode.sv
// Combinational decode of a bit position to an N-bit one-hot, flagging positions outside the vector.
// Zero latency; no flow control of its own.
module pos_onehot_decode
   import pos_codec_pkg::*;
#(
   parameter int N     = 8,
   parameter int POS_W = $clog2(N)
) (
   input  logic [POS_W-1:0] pos,
   output logic [N-1:0]     oh,
   output logic             range_err
);

   // Only the low N bits matter; the rest are always zero.
   logic [MAX_N-1:0] oh_full_unused;

   assign oh_full_unused = onehot_of(32'(pos), N);
   assign oh             = oh_full_unused[N-1:0];
   assign range_err      = 32'(pos) >= 32'(N);

endmodule

// File: rtl/pos_vector_rebuild.sv
// Rebuilds an N-bit mask from a framed stream of set-bit positions; the vector is valid the cycle after the last beat.
// Backpressure: while a finished vector waits for vec_ready, pos_ready drops; retiring and a new beat may share a cycle.
module pos_vector_rebuild
   import pos_codec_pkg::*;
#(
   parameter  int N     = 8,
   localparam int POS_W = $clog2(N),
   localparam int CNT_W = POS_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pos_valid,
   output logic             pos_ready,
   input  logic [POS_W-1:0] pos,
   input  logic             pos_last,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [N-1:0]     vec_data,
   output logic [CNT_W-1:0] vec_count,
   output logic             vec_dup,
   output logic             vec_range
);

   rebuild_state_t   state, state_nx;
   logic [N-1:0]     acc, oh;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic             dup, rng, range_err, beat, frame_dup, frame_rng;

   pos_onehot_decode #(.N(N), .POS_W(POS_W)) u_decode (
      .pos       (pos),
      .oh        (oh),
      .range_err (range_err)
   );

   assign pos_ready = (state == ACCUM) || vec_ready;
   assign beat      = pos_valid && pos_ready;
   assign vec_valid = (state == HOLD);

   // The accumulator is cleared when a frame closes, so it is already the base for the next frame's first beat.
   assign frame_dup = dup || ((acc & oh) != '0);
   assign frame_rng = rng || range_err;
   assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nx = state;
      if (beat && pos_last) begin
         state_nx = HOLD;
      end else if ((state == HOLD) && vec_ready) begin
         state_nx = ACCUM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         dup <= 1'b0;
         rng <= 1'b0;
      end else if (beat) begin
         if (pos_last) begin
            acc <= '0;
            cnt <= '0;
            dup <= 1'b0;
            rng <= 1'b0;
         end else begin
            acc <= acc | oh;
            cnt <= cnt_inc;
            dup <= frame_dup;
            rng <= frame_rng;
         end
      end
   end

   // Output registers only load on a closing beat, so they hold while the vector is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_data  <= '0;
         vec_count <= '0;
         vec_dup   <= 1'b0;
         vec_range <= 1'b0;
      end else if (beat && pos_last) begin
         vec_data  <= acc | oh;
         vec_count <= cnt_inc;
         vec_dup   <= frame_dup;
         vec_range <= frame_rng;
      end
   end

endmodule
